mcproc_controller: RTL and testbench

Multi-cycle successor to the single-cycle processor controller. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, with ready/valid handshakes to variable-latency instruction and data memories. It decodes the same op1/op2 instruction classes and drives the datapath control signals per state. It also counts retired instructions. It sits between the IR/register file/ALU datapath and the memory ports.

---
 rtl/mcproc_pkg.sv | 53 +++++
 rtl/mcproc_decode.sv | 15 +
 rtl/mcproc_controller.sv | 151 +++++++++++++++
 tb/tb_mcproc_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcproc_pkg.sv
// Shared types for the multi-cycle processor controller.
//   state_e    : FSM state encoding (also driven out on the state port)
//   wrt_sel_e  : register-file writeback source select
//   pc_sel_e   : next-PC source select
//   op_class_t : instruction classes decoded from op1/op2
//   decode_class() : pure class decode used by mcproc_decode
package mcproc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    WSEL_ALU = 2'd0,
    WSEL_MEM = 2'd1,
    WSEL_PC  = 2'd2
  } wrt_sel_e;

  typedef enum logic [1:0] {
    PSEL_SEQ = 2'd0,
    PSEL_BR  = 2'd1,
    PSEL_ALU = 2'd2
  } pc_sel_e;

  typedef struct packed {
    logic br;
    logic sw;
    logic jal;
    logic lw;
    logic cmp;
    logic wrt;
    logic mvhi;
  } op_class_t;

  // Only the low two bits of op2 take part in class decode.
  function automatic op_class_t decode_class(input logic [3:0] op1,
                                             input logic [1:0] op2_lo);
    op_class_t c;
    c.br   = op1[2] & ~op1[0];
    c.sw   = op1[2] &  op1[0];
    c.jal  = op1[1] &  op1[0];
    c.lw   = op1[0] & ~op1[1] & ~op1[2];
    c.cmp  = op1[1] & ~op1[0];
    c.wrt  = ~op1[2];
    c.mvhi = op1[3] & ~op1[1] & op2_lo[1] & op2_lo[0];
    return c;
  endfunction

endpackage

// File: rtl/mcproc_decode.sv
// Combinational instruction-class decode.
//   op1    : primary opcode from the latched IR
//   op2_lo : low two bits of the secondary opcode
//   cls    : decoded class flags (BR/SW/JAL/LW/CMP/WRT/MVHI)
module mcproc_decode
  import mcproc_pkg::*;
(
  input  logic [3:0] op1,
  input  logic [1:0] op2_lo,
  output op_class_t  cls
);

  assign cls = decode_class(op1, op2_lo);

endmodule

// File: rtl/mcproc_controller.sv
// Multi-cycle processor controller: sequences FETCH/DECODE/EXEC/MEM/WB with
// ready-gated instruction and data memory accesses, drives datapath control
// and counts retired instructions.
//   clk, reset_n                 : clock, async active-low reset
//   run                          : permit a new fetch (sampled in FETCH)
//   op1, op2, out_cond           : latched IR opcodes, comparator result
//   imem_ready, dmem_ready       : memory completion handshakes
//   imem_rd_en, ir_wr_en         : instruction fetch request / IR latch
//   dmem_rd_en, dmem_wr_en       : data memory requests (LW / SW)
//   wrt_en_reg, wrt_sel          : register write strobe and source
//   pc_wr_en, pc_sel             : PC update strobe and source
//   use_zero_exe, use_imm_exe    : ALU operand muxing
//   is_mvhi, op_alu, op_cond     : decode outputs to ALU/comparator
//   state, retired               : current state, retired-instruction count
module mcproc_controller
  import mcproc_pkg::*;
#(
  parameter int                     OP_BIT_WIDTH = 4,
  parameter logic [OP_BIT_WIDTH-1:0] OP2_SUB     = OP_BIT_WIDTH'(2),
  parameter int                     RETIRE_BITS  = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    run,
  input  logic [OP_BIT_WIDTH-1:0] op1,
  input  logic [OP_BIT_WIDTH-1:0] op2,
  input  logic                    out_cond,
  input  logic                    imem_ready,
  input  logic                    dmem_ready,
  output logic                    imem_rd_en,
  output logic                    ir_wr_en,
  output logic                    dmem_rd_en,
  output logic                    dmem_wr_en,
  output logic                    wrt_en_reg,
  output logic [1:0]              wrt_sel,
  output logic                    pc_wr_en,
  output logic [1:0]              pc_sel,
  output logic                    use_zero_exe,
  output logic                    use_imm_exe,
  output logic                    is_mvhi,
  output logic [OP_BIT_WIDTH-1:0] op_alu,
  output logic [OP_BIT_WIDTH-1:0] op_cond,
  output logic [2:0]              state,
  output logic [RETIRE_BITS-1:0]  retired
);

  state_e                 state_q, state_d;
  logic [RETIRE_BITS-1:0] retired_q, retired_d;
  op_class_t              cls;
  logic                   retire;

  mcproc_decode u_decode (
    .op1    (op1[3:0]),
    .op2_lo (op2[1:0]),
    .cls    (cls)
  );

  // State and counter registers. Async reset abandons any outstanding
  // memory request because every strobe is decoded from state_q.
  // NOTE: sequential state uses non-blocking (<=) so all flops update from
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven,
    // so no latch is inferred; it also sends unused encodings to FETCH.
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = (run & imem_ready) ? ST_DECODE : ST_FETCH;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (cls.br)               state_d = ST_FETCH;
        else if (cls.lw | cls.sw) state_d = ST_MEM;
        else                      state_d = ST_WB;
      end
      ST_MEM: begin
        if (!dmem_ready) state_d = ST_MEM;
        else if (cls.lw) state_d = ST_WB;
        else             state_d = ST_FETCH;
      end
      ST_WB:   state_d = ST_FETCH;
      default: state_d = ST_FETCH;
    endcase
  end

  // Output logic: Moore on state_q plus decode, except the FETCH issue
  // gating and the MEM completion pulse which follow the ready inputs.
  always_comb begin
    imem_rd_en = 1'b0;
    ir_wr_en   = 1'b0;
    dmem_rd_en = 1'b0;
    dmem_wr_en = 1'b0;
    wrt_en_reg = 1'b0;
    wrt_sel    = WSEL_ALU;
    pc_wr_en   = 1'b0;
    pc_sel     = PSEL_SEQ;
    retire     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_rd_en = run;
        ir_wr_en   = run & imem_ready;
      end
      ST_EXEC: begin
        if (cls.br) begin
          pc_wr_en = 1'b1;
          pc_sel   = out_cond ? PSEL_BR : PSEL_SEQ;
          retire   = 1'b1;
        end
      end
      ST_MEM: begin
        dmem_rd_en = cls.lw;
        dmem_wr_en = cls.sw;
        // A store ends here; a load continues to WB for its writeback.
        if (dmem_ready & cls.sw) begin
          pc_wr_en = 1'b1;
          retire   = 1'b1;
        end
      end
      ST_WB: begin
        wrt_en_reg = cls.wrt;
        wrt_sel    = cls.jal ? WSEL_PC : (cls.lw ? WSEL_MEM : WSEL_ALU);
        pc_wr_en   = 1'b1;
        pc_sel     = cls.jal ? PSEL_ALU : PSEL_SEQ;
        retire     = 1'b1;
      end
      default: ;
    endcase
  end

  assign retired_d = retired_q + {{(RETIRE_BITS-1){1'b0}}, retire};

  // Datapath decode: compares and branches both evaluate a subtract.
  assign use_zero_exe = (cls.br & op2[2]) | cls.mvhi;
  assign use_imm_exe  = op1[3] | cls.sw;
  assign is_mvhi      = cls.mvhi;
  assign op_alu       = (cls.cmp | cls.br) ? OP2_SUB : op2;
  assign op_cond      = op2;

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mcproc_controller.sv
module tb_mcproc_controller;

  localparam int         RB  = 4;
  localparam logic [3:0] SUB = 4'b0010;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          run, out_cond, imem_ready, dmem_ready;
  logic [3:0]    op1, op2;
  logic          imem_rd_en, ir_wr_en, dmem_rd_en, dmem_wr_en, wrt_en_reg;
  logic [1:0]    wrt_sel, pc_sel;
  logic          pc_wr_en, use_zero_exe, use_imm_exe, is_mvhi;
  logic [3:0]    op_alu, op_cond;
  logic [2:0]    state;
  logic [RB-1:0] retired;

  int checks = 0;
  int errors = 0;
  logic [RB-1:0] exp_retired;

  typedef struct {
    logic [63:0] trace;
    int          len;
    logic [1:0]  pc_sel;
    int          wrt_n;
    logic [1:0]  wrt_sel;
    int          rd_n;
    int          wr_n;
    logic        uz;
    logic        ui;
    logic [3:0]  alu;
  } exp_t;

  exp_t sb[$];

  mcproc_controller #(.OP_BIT_WIDTH(4), .OP2_SUB(SUB), .RETIRE_BITS(RB)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .op1(op1), .op2(op2),
    .out_cond(out_cond), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_rd_en(imem_rd_en), .ir_wr_en(ir_wr_en), .dmem_rd_en(dmem_rd_en),
    .dmem_wr_en(dmem_wr_en), .wrt_en_reg(wrt_en_reg), .wrt_sel(wrt_sel),
    .pc_wr_en(pc_wr_en), .pc_sel(pc_sel), .use_zero_exe(use_zero_exe),
    .use_imm_exe(use_imm_exe), .is_mvhi(is_mvhi), .op_alu(op_alu),
    .op_cond(op_cond), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected behaviour of one instruction, from the opcode class equations.
  function automatic exp_t model(input logic [3:0] o1, input logic [3:0] o2,
                                 input logic cond, input int w);
    exp_t e;
    logic br, sw, jal, lw, cmp, wrt, mvhi, in_wb;
    br   = o1[2] & ~o1[0];
    sw   = o1[2] &  o1[0];
    jal  = o1[1] &  o1[0];
    lw   = o1[0] & ~o1[1] & ~o1[2];
    cmp  = o1[1] & ~o1[0];
    wrt  = ~o1[2];
    mvhi = o1[3] & ~o1[1] & o2[1] & o2[0];
    e.trace = 64'o0012;
    e.len   = 3;
    if (!br) begin
      if (lw | sw) begin
        for (int i = 0; i <= w; i++) begin
          e.trace = {e.trace[60:0], 3'd3};
          e.len++;
        end
      end
      if (!sw) begin
        e.trace = {e.trace[60:0], 3'd4};
        e.len++;
      end
    end
    in_wb     = !br && !sw;
    e.pc_sel  = br ? {1'b0, cond} : (sw ? 2'd0 : (jal ? 2'd2 : 2'd0));
    e.wrt_n   = in_wb ? int'(wrt) : 0;
    e.wrt_sel = in_wb ? (jal ? 2'd2 : (lw ? 2'd1 : 2'd0)) : 2'd0;
    e.rd_n    = lw ? w + 1 : 0;
    e.wr_n    = sw ? w + 1 : 0;
    e.uz      = (br & o2[2]) | mvhi;
    e.ui      = o1[3] | sw;
    e.alu     = (cmp | br) ? SUB : o2;
    return e;
  endfunction

  // Issue one instruction with zero-wait fetch and w wait cycles on data
  // memory, observe it until its PC update, then score it.
  task automatic run_instr(input string name, input logic [3:0] o1,
                           input logic [3:0] o2, input logic cond, input int w);
    exp_t e, got;
    int mem_cnt = 0;
    bit done = 0;
    logic irw = 1'b0;
    sb.push_back(model(o1, o2, cond, w));
    exp_retired = exp_retired + 1'b1;
    got = '{trace: 64'd0, len: 0, pc_sel: 2'd3, wrt_n: 0, wrt_sel: 2'd3,
            rd_n: 0, wr_n: 0, uz: 1'bx, ui: 1'bx, alu: 4'hx};
    op1 = o1; op2 = o2; out_cond = cond; run = 1'b1; imem_ready = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      dmem_ready = (state == 3'd3) && (mem_cnt >= w);
      #1;
      if (c == 0) irw = ir_wr_en;
      got.trace = {got.trace[60:0], state};
      got.len++;
      if (state == 3'd3) mem_cnt++;
      got.wrt_n += int'(wrt_en_reg);
      got.rd_n  += int'(dmem_rd_en);
      got.wr_n  += int'(dmem_wr_en);
      if (state == 3'd2) begin
        got.uz  = use_zero_exe;
        got.ui  = use_imm_exe;
        got.alu = op_alu;
      end
      if (pc_wr_en) begin
        got.pc_sel  = pc_sel;
        got.wrt_sel = wrt_sel;
        done = 1;
      end
      @(posedge clk); #1;
      run = 1'b0;
      dmem_ready = 1'b0;
    end
    check({name, "_finished"}, done, 1'b1);
    e = sb.pop_front();
    check({name, "_ir_wr_en"}, irw, 1'b1);
    check({name, "_trace"}, got.trace, e.trace);
    check({name, "_cycles"}, got.len, e.len);
    check({name, "_pc_sel"}, got.pc_sel, e.pc_sel);
    check({name, "_wrt_pulses"}, got.wrt_n, e.wrt_n);
    check({name, "_wrt_sel"}, got.wrt_sel, e.wrt_sel);
    check({name, "_rd_cycles"}, got.rd_n, e.rd_n);
    check({name, "_wr_cycles"}, got.wr_n, e.wr_n);
    check({name, "_use_zero"}, got.uz, e.uz);
    check({name, "_use_imm"}, got.ui, e.ui);
    check({name, "_op_alu"}, got.alu, e.alu);
    check({name, "_retired"}, retired, exp_retired);
    check({name, "_back_in_fetch"}, state, 3'd0);
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0; op1 = '0; op2 = '0; out_cond = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; exp_retired = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state, 3'd0);
    check("rst_retired", retired, 4'd0);
    check("rst_strobes", {imem_rd_en, ir_wr_en, dmem_rd_en, dmem_wr_en,
                          wrt_en_reg, pc_wr_en}, 6'd0);
    check("rst_sels", {wrt_sel, pc_sel}, 4'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Idle with run low, then a request stalled on imem_ready.
    for (int i = 0; i < 3; i++) begin
      check("idle_imem_rd_en", imem_rd_en, 1'b0);
      check("idle_state", state, 3'd0);
      @(posedge clk); #1;
    end
    run = 1'b1; imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("stall_imem_rd_en", imem_rd_en, 1'b1);
      check("stall_ir_wr_en", ir_wr_en, 1'b0);
      @(posedge clk); #1;
      check("stall_state", state, 3'd0);
    end
    run = 1'b0;

    run_instr("alu",    4'b1000, 4'b0000, 1'b0, 0);
    run_instr("br_t",   4'b0100, 4'b0100, 1'b1, 0);
    run_instr("br_nt",  4'b0100, 4'b0100, 1'b0, 0);
    run_instr("lw_w3",  4'b0001, 4'b0000, 1'b0, 3);
    run_instr("jal",    4'b0011, 4'b0001, 1'b0, 0);
    run_instr("sw",     4'b0101, 4'b0000, 1'b0, 0);
    run_instr("sw_w2",  4'b0101, 4'b0110, 1'b0, 2);
    run_instr("mvhi",   4'b1000, 4'b0011, 1'b0, 0);
    run_instr("cmp",    4'b0010, 4'b0111, 1'b1, 0);
    check("is_mvhi_decode", is_mvhi, 1'b0);
    check("op_cond_passthru", op_cond, 4'b0111);

    // Reset while a store waits in MEM.
    begin
      bit in_mem = 0;
      op1 = 4'b0101; op2 = 4'b0000; run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0;
      for (int c = 0; c < 10 && !in_mem; c++) begin
        @(posedge clk); #1;
        run = 1'b0;
        in_mem = (state == 3'd3);
      end
      check("rstmem_reached_mem", in_mem, 1'b1);
      @(posedge clk); #1;
      check("rstmem_wr_pending", dmem_wr_en, 1'b1);
      reset_n = 1'b0;
      #1;
      check("rstmem_state", state, 3'd0);
      check("rstmem_dmem_wr_en", dmem_wr_en, 1'b0);
      check("rstmem_retired", retired, 4'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      exp_retired = '0;
      @(posedge clk); #1;
      check("rstmem_idle_after", state, 3'd0);
    end

    // 17 mixed instructions wrap the 4-bit counter to 1.
    for (int i = 0; i < 17; i++) begin
      run_instr("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end
    check("wrap_retired", retired, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
